fetch_exec_sequencer: RTL and testbench
=======================================

FETCH_EXEC_SEQUENCER -- requirements
Module: fetch_exec_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, memory-ack wait limit in cycles (range 2..255); used only when the Configuration macro is defined.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  reset, synchronous, active-high.
REQ-004 Port: start  in  1  level; begins execution when sampled high in IDLE.
REQ-005 Port: halt_req  in  1  level; stop after the current instruction retires.
REQ-006 Port: pc  in  8  current value from the program counter.
REQ-007 Port: pc_inc  out  1  one-cycle pulse; program counter increments by one.
REQ-008 Port: mem_req  out  1  memory request, held until acknowledged.
REQ-009 Port: mem_we  out  1  1 = store, 0 = read; valid while mem_req=1.
REQ-010 Port: mem_addr  out  8  request address; valid while mem_req=1.
REQ-011 Port: mem_ack  in  1  one-cycle completion strobe from memory.
REQ-012 Port: mem_rdata  in  32  read data; valid in the mem_ack cycle.
REQ-013 Port: ir  out  32  instruction register.
REQ-014 Port: sel_ldr / sel_str / sel_add  out  1 each  datapath selects.
REQ-015 Port: busy  out  1  high in every state except IDLE and HALTED.
REQ-016 Port: halted  out  1  high in HALTED.
REQ-017 Port: err  out  1  sticky ack-timeout flag.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, ADVANCE and HALTED; all outputs SHALL be registered.
REQ-019 IDLE: start=1 -> FETCH on the next cycle; otherwise remain in IDLE.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack, ir<=mem_rdata -> DECODE.
REQ-021 Opcode ir[31:28] SHALL decode as: 0x0 NOP, 0x1 ADD, 0x2 LDR, 0x3 STR, 0xF HALT; any other value executes as NOP.
REQ-022 DECODE: HALT -> HALTED with no pc_inc; LDR/STR -> MEM; all others -> EXEC.
REQ-023 EXEC: sel_add=1 for exactly one cycle if the opcode is ADD (0 for NOP) -> ADVANCE.
REQ-024 MEM: mem_req=1, mem_addr=ir[7:0], mem_we=1 for STR; sel_ldr (LDR) or sel_str (STR) held high through the mem_ack cycle -> ADVANCE.
REQ-025 ADVANCE: pc_inc=1 for one cycle; then halt_req=1 -> IDLE, else -> FETCH.
REQ-026 With a zero-wait ack, every non-HALT instruction SHALL take exactly 4 cycles, and each wait cycle SHALL add one cycle.
REQ-027 mem_ack outside FETCH/MEM, or while mem_req=0, SHALL be ignored.
REQ-028 mem_req SHALL deassert in the cycle after mem_ack.
REQ-029 At most one of sel_ldr, sel_str, sel_add SHALL be high in any cycle.
REQ-030 pc wrap-around 0xFF->0x00 is owned by the counter; the sequencer SHALL fetch from whatever pc presents.
REQ-031 start in a non-IDLE state and halt_req in any state other than ADVANCE SHALL be ignored; halt_req is a level and is sampled only in ADVANCE.
REQ-032 HALTED SHALL be exited only by reset.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE and drive ir=0, err=0 and all other outputs to 0, overriding any transaction in progress.
REQ-034 Reset during a pending memory request SHALL drop mem_req on the next cycle, with no pc_inc and no ir update.

Configuration
REQ-035 Macro SEQ_ACK_TIMEOUT_EN defined: a counter SHALL count consecutive mem_req=1 cycles without mem_ack in FETCH/MEM. When it reaches TIMEOUT_CYCLES, the sequencer SHALL drop mem_req, set err=1 and go to HALTED; the counter SHALL clear on ack or state exit.
REQ-036 Macro SEQ_ACK_TIMEOUT_EN undefined: the sequencer SHALL wait indefinitely for mem_ack, err SHALL be constant 0, and no timeout counter SHALL exist.

Verification
REQ-037 Reset, pc=0x00, start=1, memory returns 0x10000000 (ADD) with zero wait -> sel_add high for one cycle in cycle 3, pc_inc in cycle 4, next FETCH in cycle 5.
REQ-038 LDR 0x20000042 with a 3-cycle ack delay in MEM -> mem_addr=0x42, mem_we=0, sel_ldr high for 4 cycles, then one pc_inc.
REQ-039 STR 0x300000A5 -> mem_we=1 and mem_addr=0xA5 in MEM; sel_str high; sel_ldr and sel_add remain 0.
REQ-040 HALT 0xF0000000 at pc=0x07 -> halted=1, busy=0, no pc_inc; start ignored until reset.
REQ-041 halt_req=1 asserted during a NOP -> pc_inc still pulses, then IDLE; start=1 resumes fetch at the new pc.
REQ-042 SEQ_ACK_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ack withheld in FETCH -> mem_req drops after 16 cycles, err=1, halted=1; reset clears err.

Source files
------------

// File: rtl/fetch_exec_sequencer.sv
// Fetch/decode/execute control sequencer with registered outputs.
// Optional memory-ack timeout: define SEQ_ACK_TIMEOUT_EN.
module fetch_exec_sequencer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic [7:0]  pc,
  output logic        pc_inc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic        sel_ldr,
  output logic        sel_str,
  output logic        sel_add,
  output logic        busy,
  output logic        halted,
  output logic        err
);
  // state     | meaning
  // S_IDLE    | waiting for start
  // S_FETCH   | instruction read at pc, wait for ack
  // S_DECODE  | opcode in ir is examined
  // S_EXEC    | register-only instruction (ADD/NOP)
  // S_MEM     | data load/store at ir[7:0], wait for ack
  // S_ADVANCE | pc increment pulse, halt_req sampled
  // S_HALTED  | stopped until reset
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_ADVANCE, S_HALTED
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_q, state_d;
  logic        ack_ok, timeout;
  logic        is_add, is_ldr, is_str, is_halt;
  logic        pc_inc_d, mem_req_d, mem_we_d, sel_ldr_d, sel_str_d, sel_add_d;
  logic        busy_d, halted_d;
  logic [7:0]  mem_addr_d;
  logic [31:0] ir_d;

  assign ack_ok  = mem_ack & mem_req;
  assign is_add  = (ir[31:28] == OP_ADD);
  assign is_ldr  = (ir[31:28] == OP_LDR);
  assign is_str  = (ir[31:28] == OP_STR);
  assign is_halt = (ir[31:28] == OP_HALT);

`ifdef SEQ_ACK_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q;
  logic       waiting;

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !ack_ok;
  assign timeout = waiting && (wait_cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      err        <= 1'b0;
    end else begin
      err <= err | timeout;
      if (waiting && !timeout) wait_cnt_q <= wait_cnt_q + 8'd1;
      else                     wait_cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   if (timeout) state_d = S_HALTED;
                 else if (ack_ok) state_d = S_DECODE;
      S_DECODE:  if (is_halt) state_d = S_HALTED;
                 else if (is_ldr || is_str) state_d = S_MEM;
                 else state_d = S_EXEC;
      S_EXEC:    state_d = S_ADVANCE;
      S_MEM:     if (timeout) state_d = S_HALTED;
                 else if (ack_ok) state_d = S_ADVANCE;
      S_ADVANCE: state_d = halt_req ? S_IDLE : S_FETCH;
      S_HALTED:  state_d = S_HALTED;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d     = (state_d != S_IDLE) && (state_d != S_HALTED);
    halted_d   = (state_d == S_HALTED);
    pc_inc_d   = (state_d == S_ADVANCE);
    mem_req_d  = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d   = (state_d == S_MEM) && is_str;
    sel_ldr_d  = (state_d == S_MEM) && is_ldr;
    sel_str_d  = (state_d == S_MEM) && is_str;
    sel_add_d  = (state_d == S_EXEC) && is_add;
    mem_addr_d = 8'h00;
    // Leaving ADVANCE, the counter increments on this same edge, so the
    // registered fetch address must anticipate it; later FETCH cycles track pc.
    if (state_d == S_FETCH)    mem_addr_d = (state_q == S_ADVANCE) ? pc + 8'd1 : pc;
    else if (state_d == S_MEM) mem_addr_d = ir[7:0];
    ir_d = ir;
    if ((state_q == S_FETCH) && ack_ok) ir_d = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ir       <= '0;
      pc_inc   <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      sel_ldr  <= 1'b0;
      sel_str  <= 1'b0;
      sel_add  <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir       <= ir_d;
      pc_inc   <= pc_inc_d;
      mem_req  <= mem_req_d;
      mem_we   <= mem_we_d;
      mem_addr <= mem_addr_d;
      sel_ldr  <= sel_ldr_d;
      sel_str  <= sel_str_d;
      sel_add  <= sel_add_d;
      busy     <= busy_d;
      halted   <= halted_d;
    end
  end
endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Bench for fetch_exec_sequencer: per-instruction expected-trace model plus literal pins.
module tb_fetch_exec_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, halt_req = 1'b0;
  logic [7:0]  pc;
  logic        pc_inc, mem_req, mem_we, mem_ack = 1'b0;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = 32'h0, ir;
  logic        sel_ldr, sel_str, sel_add, busy, halted, err;

  fetch_exec_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .pc(pc),
    .pc_inc(pc_inc), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .sel_ldr(sel_ldr),
    .sel_str(sel_str), .sel_add(sel_add), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, halted, err, req, we;
    logic [7:0] addr;
    logic ldr, str, add, inc;
    logic [31:0] irv;
  } vec_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } lit_t;

  vec_t  expq[$];
  lit_t  litq[$];
  logic [31:0] mem [256];
  logic [7:0]  pc_init = 8'h00, m_pc;
  logic [31:0] m_ir;
  int fw = 0, dw = 0, ack_cnt = 0;
  logic stray = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  int add_cyc = 0, inc_cyc = 0, rise_cyc = 0, n_inc = 0, n_ldr = 0, n_str = 0, n_add = 0;
  logic [7:0] rise_addr = 0, ldr_addr = 0, str_addr = 0;
  logic prev_req = 1'b0;

  // External program counter owned by the environment.
  always @(posedge clk) begin
    if (reset) pc <= pc_init;
    else if (pc_inc) pc <= pc + 8'd1;
  end

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_req) begin
      if (ack_cnt >= ((sel_ldr || sel_str) ? dw : fw)) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
      end else ack_cnt++;
    end else begin
      ack_cnt = 0;
      if (stray) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end
    end
  end

  always @(negedge clk) begin
    vec_t e, a;
    lit_t l;
    a = {busy, halted, err, mem_req, mem_we, mem_addr, sel_ldr, sel_str, sel_add, pc_inc, ir};
    if (expq.size() != 0) begin
      e = expq.pop_front();
      cyc++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace cyc=%0d got=%h want=%h", cyc, a, e);
      end
    end
    if (mem_req && !prev_req) begin rise_cyc = cyc; rise_addr = mem_addr; end
    prev_req = mem_req;
    if (sel_add) begin add_cyc = cyc; n_add++; end
    if (pc_inc)  begin inc_cyc = cyc; n_inc++; end
    if (sel_ldr) begin n_ldr++; ldr_addr = mem_addr; end
    if (sel_str) n_str++;
    if (mem_we)  str_addr = mem_addr;
    while (litq.size() != 0) begin
      l = litq.pop_front();
      checks++;
      if (l.act !== l.exp) begin
        errors++;
        $display("FAIL %s got=%0h want=%0h", l.name, l.act, l.exp);
      end
    end
  end

  function automatic vec_t mk(bit b, bit h, bit er, bit rq, bit we, logic [7:0] ad,
                              bit ld, bit st, bit ad2, bit inc, logic [31:0] irv);
    return {b, h, er, rq, we, ad, ld, st, ad2, inc, irv};
  endfunction

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_t l;
    l.name = name; l.act = act; l.exp = exp;
    litq.push_back(l);
  endtask

  task automatic push_n(input int n, input vec_t v);
    for (int i = 0; i < n; i++) expq.push_back(v);
  endtask

  // Expected trace of one instruction from its first fetch cycle onward.
  task automatic model_instr(input bit hreq);
    logic [31:0] ins;
    logic [3:0]  op;
    ins = mem[m_pc];
    op  = ins[31:28];
    push_n(fw + 1, mk(1, 0, 0, 1, 0, m_pc, 0, 0, 0, 0, m_ir));
    m_ir = ins;
    push_n(1, mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, m_ir));
    if (op == 4'hF) begin
      push_n(1, mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, m_ir));
      return;
    end
    if (op == 4'h2 || op == 4'h3)
      push_n(dw + 1, mk(1, 0, 0, 1, op == 4'h3, ins[7:0], op == 4'h2, op == 4'h3, 0, 0, m_ir));
    else
      push_n(1, mk(1, 0, 0, 0, 0, 8'h00, 0, 0, op == 4'h1, 0, m_ir));
    push_n(1, mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, m_ir));
    m_pc = m_pc + 8'd1;
    if (hreq) push_n(1, mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, m_ir));
  endtask

  task automatic do_reset(input logic [7:0] p);
    pc_init = p;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_pc = p;
    m_ir = 32'h0;
  endtask

  task automatic go(input vec_t first);
    expq.push_back(first);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (expq.size() != 0 || litq.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > max) begin
        lit("drain_bound", 32'd1, 32'd0);
        expq.delete();
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  vec_t idle0, halt_v;
  int base, inc0, ldr0, add0, str0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hF000_0000;
    repeat (2) @(posedge clk); #1;

    // ADD then HALT from pc 0, zero-wait memory; start ignored once halted
    mem[8'h00] = 32'h1000_0000;
    mem[8'h01] = 32'hF000_0000;
    do_reset(8'h00);
    fw = 0; dw = 0;
    base = cyc;
    idle0 = mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'h0);
    go(idle0);
    model_instr(0);
    model_instr(0);
    halt_v = mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'hF000_0000);
    push_n(2, halt_v);
    drain(50);
    lit("add_cycle", add_cyc - base - 1, 3);
    lit("inc_cycle", inc_cyc - base - 1, 4);
    lit("refetch_cycle", rise_cyc - base - 1, 5);
    lit("refetch_addr", rise_addr, 8'h01);
    go(halt_v);
    push_n(3, halt_v);
    drain(20);

    // LDR with 3-cycle data ack, then HALT at pc 0x07
    mem[8'h06] = 32'h2000_0042;
    mem[8'h07] = 32'hF000_0000;
    mem[8'h42] = 32'h1234_5678;
    do_reset(8'h06);
    fw = 0; dw = 3;
    inc0 = n_inc; ldr0 = n_ldr;
    go(idle0);
    model_instr(0);
    model_instr(0);
    push_n(2, halt_v);
    drain(50);
    lit("ldr_cycles", n_ldr - ldr0, 4);
    lit("ldr_pc_inc", n_inc - inc0, 1);
    lit("ldr_addr", ldr_addr, 8'h42);

    // STR with 1-cycle data ack and 2-cycle fetch ack
    mem[8'h30] = 32'h3000_00A5;
    mem[8'h31] = 32'hF000_0000;
    do_reset(8'h30);
    fw = 2; dw = 1;
    ldr0 = n_ldr; add0 = n_add; str0 = n_str;
    go(idle0);
    model_instr(0);
    model_instr(0);
    push_n(1, halt_v);
    drain(50);
    lit("str_addr", str_addr, 8'hA5);
    lit("str_cycles", n_str - str0, 2);
    lit("str_no_ldr", n_ldr - ldr0, 0);
    lit("str_no_add", n_add - add0, 0);

    // Stray ack in IDLE, halt_req on NOP, resume across pc wrap
    mem[8'hFE] = 32'h0000_0000;
    mem[8'hFF] = 32'h7ABC_DE01;
    mem[8'h00] = 32'h1000_0000;
    mem[8'h01] = 32'hF000_0000;
    do_reset(8'hFE);
    fw = 0; dw = 0;
    inc0 = n_inc; add0 = n_add;
    stray = 1'b1;
    expq.push_back(idle0);
    @(posedge clk); #1;
    stray = 1'b0;
    expq.push_back(idle0);
    @(posedge clk); #1;
    halt_req = 1'b1;
    go(idle0);
    model_instr(1);
    drain(30);
    halt_req = 1'b0;
    go(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, m_ir));
    model_instr(0);
    model_instr(0);
    model_instr(0);
    push_n(1, halt_v);
    drain(60);
    lit("wrap_last_fetch", rise_addr, 8'h01);
    lit("wrap_add_count", n_add - add0, 1);
    lit("wrap_inc_count", n_inc - inc0, 3);

    // Reset while a fetch is still waiting for its ack
    do_reset(8'h50);
    fw = 10;
    inc0 = n_inc;
    go(idle0);
    push_n(5, mk(1, 0, 0, 1, 0, 8'h50, 0, 0, 0, 0, 32'h0));
    push_n(2, idle0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drain(20);
    lit("reset_no_inc", n_inc - inc0, 0);

`ifdef SEQ_ACK_TIMEOUT_EN
    // Ack withheld in FETCH until the timeout fires, then reset clears err
    do_reset(8'h20);
    fw = 40;
    go(idle0);
    push_n(16, mk(1, 0, 0, 1, 0, 8'h20, 0, 0, 0, 0, 32'h0));
    push_n(3, mk(0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 32'h0));
    drain(40);
    do_reset(8'h20);
    push_n(2, idle0);
    drain(10);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
